// File: rtl/iir_inverse_fir.sv
// iir_inverse_fir: sequential single-multiplier FIR A(z) in Q(DATA_W-FRAC_W).FRAC_W, the exact inverse of the all-pole filter 1/A(z)
// Ports: clk; rst (async, active-low); in_valid/in_ready/in_data carry sample x[n];
//        coef_we/coef_addr/coef_data write coefficient a[k], taken only in IDLE;
//        out_valid/out_ready/out_data carry y[n]; sat_flag marks a clipped y[n].
// Option: define IIR_INV_ROUND_EN to round half toward +inf before the output shift.
//         When it is not defined, the output is truncated toward -inf.
module iir_inverse_fir #(
    parameter int DATA_W = 32,
    parameter int FRAC_W = 16,
    parameter int TAPS   = 3
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [DATA_W-1:0] in_data,
    input  logic              coef_we,
    input  logic [3:0]        coef_addr,
    input  logic [DATA_W-1:0] coef_data,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_data,
    output logic              sat_flag
);
    localparam int AW = 2 * DATA_W + 4;
    localparam int KW = $clog2(TAPS);
    localparam logic signed [AW-1:0] MAXV = (AW'(1) << (DATA_W - 1)) - AW'(1);
    localparam logic signed [AW-1:0] MINV = -(AW'(1) << (DATA_W - 1));

    typedef enum logic [1:0] {IDLE, MAC, HOLD} state_t;

    state_t                     state;
    logic signed [DATA_W-1:0]   coef [TAPS];
    logic signed [DATA_W-1:0]   hist [TAPS];
    logic signed [AW-1:0]       acc, rnd, shf;
    logic signed [2*DATA_W-1:0] prod;
    logic [KW-1:0]              k;
    logic                       last, accept, hi, lo;

    // Reset coefficients give A(z) = 1 - 0.75 z^-1 + 0.25 z^-2.
    function automatic logic [DATA_W-1:0] coef_init(input int i);
        return i == 0 ? DATA_W'(1) << FRAC_W :
               i == 1 ? DATA_W'(0) - (DATA_W'(3) << (FRAC_W - 2)) :
               i == 2 ? DATA_W'(1) << (FRAC_W - 2) : '0;
    endfunction

    // A coefficient write takes the IDLE cycle, so no sample is accepted alongside it.
    assign in_ready = rst && state == IDLE && !coef_we;
    assign accept   = in_valid && in_ready;
    assign prod     = coef[k] * hist[k];
`ifdef IIR_INV_ROUND_EN
    assign rnd = acc + (AW'(1) << (FRAC_W - 1));
`else
    assign rnd = acc;
`endif
    assign shf = rnd >>> FRAC_W;
    assign hi  = shf > MAXV;
    assign lo  = shf < MINV;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < TAPS; i++) coef[i] <= coef_init(i);
        end else begin
            for (int i = 0; i < TAPS; i++)
                if (coef_we && state == IDLE && coef_addr == 4'(i)) coef[i] <= coef_data;
        end
    end

    // The MAC phase runs TAPS accumulate cycles, then spends one more cycle
    // (flagged by last) scaling and saturating the finished sum into the output register.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state     <= IDLE;
            acc       <= '0;
            k         <= '0;
            last      <= 1'b0;
            out_valid <= 1'b0;
            out_data  <= '0;
            sat_flag  <= 1'b0;
            for (int i = 0; i < TAPS; i++) hist[i] <= '0;
        end else begin
            case (state)
                IDLE: if (accept) begin
                    hist[0] <= in_data;
                    for (int i = 1; i < TAPS; i++) hist[i] <= hist[i-1];
                    acc   <= '0;
                    k     <= '0;
                    last  <= 1'b0;
                    state <= MAC;
                end
                MAC: if (!last) begin
                    acc  <= acc + AW'(prod);
                    k    <= k == KW'(TAPS - 1) ? '0 : k + 1'b1;
                    last <= k == KW'(TAPS - 1);
                end else begin
                    out_data  <= hi ? MAXV[DATA_W-1:0] : lo ? MINV[DATA_W-1:0] : shf[DATA_W-1:0];
                    sat_flag  <= hi || lo;
                    out_valid <= 1'b1;
                    state     <= HOLD;
                end
                HOLD: if (out_ready) begin
                    out_valid <= 1'b0;
                    state     <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_iir_inverse_fir.sv
// tb_iir_inverse_fir: scoreboard bench for iir_inverse_fir against a dot-product reference model
// The driver pushes predictions into a queue when a sample is accepted.
// A negedge monitor pops from that queue on each output transfer and also checks handshake rules.
module tb_iir_inverse_fir;
    localparam int TAPS = 3;

    typedef struct {
        logic [31:0] d;
        logic        s;
        int          cyc;
        bit          lb;
    } exp_t;

    logic        clk = 0, rst = 0, in_valid = 0, coef_we = 0, out_ready = 1;
    logic        in_ready, out_valid, sat_flag;
    logic [31:0] in_data = 0, coef_data = 0, out_data;
    logic [3:0]  coef_addr = 0;

    exp_t        sb[$];
    exp_t        e;
    int          errors = 0, checks = 0, cyc = 0;
    logic [31:0] mc[TAPS], mh[TAPS];
    logic        ph = 0, pov = 0, ps = 0;
    logic [31:0] pd = 0;

    iir_inverse_fir #(.DATA_W(32), .FRAC_W(16), .TAPS(TAPS)) dut (
        .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready), .in_data(in_data),
        .coef_we(coef_we), .coef_addr(coef_addr), .coef_data(coef_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .sat_flag(sat_flag)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got %h required %h", nm, act, req);
        end
    endtask

    function automatic void model_reset();
        for (int i = 0; i < TAPS; i++) begin
            mh[i] = '0;
            mc[i] = '0;
        end
        mc[0] = 32'h00010000;
        mc[1] = 32'hFFFF4000;
        mc[2] = 32'h00004000;
    endfunction

    // y = sat(floor((sum a_k * x[n-k] [+ 0.5 LSB]) / 2^16)).
    function automatic exp_t predict(input bit lb);
        logic signed [69:0] a = '0;
        logic signed [69:0] qv;
        exp_t r;
        for (int i = 0; i < TAPS; i++) a += $signed(mc[i]) * $signed(mh[i]);
`ifdef IIR_INV_ROUND_EN
        a += 70'sd32768;
`endif
        qv = a >>> 16;
        if (qv > 70'sd2147483647) begin
            r.d = 32'h7FFFFFFF;
            r.s = 1'b1;
        end else if (qv < -70'sd2147483648) begin
            r.d = 32'h80000000;
            r.s = 1'b1;
        end else begin
            r.d = qv[31:0];
            r.s = 1'b0;
        end
        r.cyc = cyc;
        r.lb  = lb;
        return r;
    endfunction

    function automatic logic [31:0] rnd_val();
        logic [31:0] r = $urandom;
        return 32'($signed(r) >>> $urandom_range(0, 20));
    endfunction

    task automatic wait_ready();
        int t = 0;
        while (!in_ready && t < 200) begin
            @(posedge clk); #1;
            t++;
        end
        if (!in_ready) check("ready_timeout", 32'(in_ready), 32'd1);
    endtask

    task automatic send(input logic [31:0] x, input bit lb);
        wait_ready();
        if (!in_ready) return;
        in_valid = 1;
        in_data  = x;
        @(posedge clk); #1;
        for (int i = TAPS - 1; i > 0; i--) mh[i] = mh[i-1];
        mh[0] = x;
        sb.push_back(predict(lb));
        in_valid = 0;
        in_data  = $urandom;
    endtask

    task automatic wcoef(input logic [3:0] a, input logic [31:0] d, input bit with_sample);
        wait_ready();
        coef_we   = 1;
        coef_addr = a;
        coef_data = d;
        if (with_sample) begin
            in_valid = 1;
            in_data  = $urandom;
        end
        @(negedge clk);
        check("coef_we_blocks_ready", 32'(in_ready), 32'd0);
        @(posedge clk); #1;
        coef_we  = 0;
        in_valid = 0;
        if (a < TAPS) mc[a] = d;
    endtask

    task automatic drain();
        int t = 0;
        while (sb.size() != 0 && t < 500) begin
            @(posedge clk); #1;
            t++;
        end
        check("drain", 32'(sb.size()), 32'd0);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            ph  = 0;
            pov = 0;
        end else begin
            check("valid_ready_excl", 32'(out_valid && in_ready), 32'd0);
            if (out_valid && !pov && sb.size() > 0) check("latency", 32'(cyc - sb[0].cyc), 32'(TAPS + 1));
            if (ph) begin
                check("hold_data", out_data, pd);
                check("hold_sat", 32'(sat_flag), 32'(ps));
                check("hold_in_ready", 32'(in_ready), 32'd0);
            end
            if (out_valid && out_ready) begin
                if (sb.size() == 0) begin
                    check("unexpected_output", 32'(out_valid), 32'd0);
                end else begin
                    e = sb.pop_front();
                    check("out_data", out_data, e.d);
                    check("sat_flag", 32'(sat_flag), 32'(e.s));
                    if (e.lb) check("loopback_1lsb", 32'(out_data >= 32'h0000FFFF && out_data <= 32'h00010001), 32'd1);
                end
            end
            ph  = out_valid && !out_ready;
            pd  = out_data;
            ps  = sat_flag;
            pov = out_valid;
        end
    end

    initial begin
        #500000;
        $display("FAIL watchdog: got timeout required finish");
        $fatal(1);
    end

    initial begin
        longint y, y1, y2;
        int t;
        model_reset();
        repeat (2) @(negedge clk);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_out_data", out_data, 32'd0);
        check("rst_sat_flag", 32'(sat_flag), 32'd0);
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check("ready_after_rst", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        // impulse through reset coefficients
        send(32'h00010000, 0);
        repeat (3) send(32'h0, 0);
        drain();
        // loopback: unit step through the all-pole filter 1/A(z), then back through A(z)
        y1 = 0;
        y2 = 0;
        for (int n = 0; n < 8; n++) begin
            y = 64'sd65536 + ((3 * y1 - y2) >>> 2);
            send(32'(y), 1);
            y2 = y1;
            y1 = y;
        end
        drain();
        // randomized coefficients and data
        for (int r = 0; r < 3; r++) begin
            for (int i = 0; i < TAPS; i++) wcoef(4'(i), rnd_val(), 0);
            for (int n = 0; n < 6; n++) send(rnd_val(), 0);
            drain();
        end
        // saturation
        wcoef(0, 32'h7FFF0000, 0);
        wcoef(1, 32'h0, 0);
        wcoef(2, 32'h0, 0);
        send(32'h7FFF0000, 0);
        send(32'h80000000, 0);
        drain();
        // rounding at the half-LSB boundary
        wcoef(0, 32'h00008000, 0);
        send(32'h00000001, 0);
        send(32'hFFFFFFFF, 0);
        drain();
        // a write racing a sample, an out-of-range address, and a write during MAC
        wcoef(1, 32'h00020000, 0);
        wcoef(0, 32'h00010000, 1);
        wcoef(4'd5, 32'h12345678, 0);
        send(32'h00030000, 0);
        coef_we   = 1;
        coef_addr = 0;
        coef_data = 32'h00050000;
        @(posedge clk); #1;
        coef_we = 0;
        drain();
        send(32'h00010000, 0);
        drain();
        // backpressure
        out_ready = 0;
        send(32'h00024000, 0);
        t = 0;
        while (!out_valid && t < 50) begin
            @(posedge clk); #1;
            t++;
        end
        check("bp_valid", 32'(out_valid), 32'd1);
        repeat (10) begin
            @(posedge clk); #1;
        end
        out_ready = 1;
        @(posedge clk); #1;
        @(negedge clk);
        check("bp_idle_ready", 32'(in_ready), 32'd1);
        check("bp_valid_low", 32'(out_valid), 32'd0);
        @(posedge clk); #1;
        drain();
        // reset during MAC cycle 2
        send(32'h00070000, 0);
        @(posedge clk); #1;
        rst = 0;
        @(negedge clk);
        check("abort_valid", 32'(out_valid), 32'd0);
        check("abort_ready", 32'(in_ready), 32'd0);
        sb.delete();
        model_reset();
        @(posedge clk); #1;
        rst = 1;
        @(negedge clk);
        check("abort_idle", 32'(in_ready), 32'd1);
        @(posedge clk); #1;
        send(32'h00010000, 0);
        repeat (3) send(32'h0, 0);
        drain();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
